// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Shares one 32-bit ALU between two requesters. Each requester
//               issues (op, A, B) over valid/ready. The winner's operands are
//               registered, the ALU runs for EXEC_CYCLES cycles and the result
//               (F/ZF/OF plus requester ID) is returned on a single
//               valid/ready response channel.
// Options     : `define ALU_ARB_ROUND_ROBIN_EN -> contention alternates
//               between requesters (round robin).
//               Undefined (default) -> requester 0 always wins contention.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int EXEC_CYCLES = 1,   // legal range 1..15
    parameter int CNT_W       = 16
) (
    input  logic             clock,
    input  logic             rst,          // asynchronous, active low

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [31:0]      rsp_f,
    output logic             rsp_zf,
    output logic             rsp_of,

    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_XOR = 3'd2;
    localparam logic [2:0] OP_NOR = 3'd3;
    localparam logic [2:0] OP_ADD = 3'd4;
    localparam logic [2:0] OP_SUB = 3'd5;
    localparam logic [2:0] OP_SLT = 3'd6;
    localparam logic [2:0] OP_SLL = 3'd7;

    // Counter preload: the EXEC state lasts exactly EXEC_CYCLES cycles,
    // the last of which sees the counter at zero.
    localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES - 1);

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    logic [1:0]  state;
    logic [3:0]  exec_cnt;
    logic [2:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;

    // last_grant records the most recently accepted requester. It is only
    // written on a handshake, so it also serves as the captured ID of the
    // operation currently in flight.
    logic        last_grant;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic        grant;
    logic        accept;
    logic        in_idle;
    logic        exec_done;
    logic        rsp_fire;
    logic [32:0] sum33;
    logic [31:0] alu_f;
    logic        alu_of;

    assign in_idle   = (state == ST_IDLE);
    assign exec_done = (state == ST_EXEC) && (exec_cnt == 4'd0);
    assign rsp_fire  = (state == ST_RESP) && rsp_valid && rsp_ready;
    assign busy      = !in_idle;

    // Arbitration: a lone requester always wins; contention is resolved by
    // either alternating (round robin) or fixed priority to requester 0.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
            grant = ~last_grant;
`else
            grant = 1'b0;
`endif
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    // Ready is combinational and mutually exclusive because grant selects one.
    assign req0_ready = in_idle && (grant == 1'b0) && req0_valid;
    assign req1_ready = in_idle && (grant == 1'b1) && req1_valid;
    assign accept     = req0_ready || req1_ready;

    // ALU: operates solely on the captured operand registers.
    always_comb begin
        sum33  = 33'd0;
        alu_f  = 32'd0;
        alu_of = 1'b0;
        case (op_q)
            OP_AND: alu_f = a_q & b_q;
            OP_OR:  alu_f = a_q | b_q;
            OP_XOR: alu_f = a_q ^ b_q;
            OP_NOR: alu_f = ~(a_q | b_q);
            OP_ADD: begin
                sum33  = {1'b0, a_q} + {1'b0, b_q};
                alu_f  = sum33[31:0];
                alu_of = a_q[31] ^ b_q[31] ^ sum33[31] ^ sum33[32];
            end
            OP_SUB: begin
                // Bit 32 is the borrow; together with the un-inverted B sign
                // the same XOR form yields the signed overflow.
                sum33  = {1'b0, a_q} - {1'b0, b_q};
                alu_f  = sum33[31:0];
                alu_of = a_q[31] ^ b_q[31] ^ sum33[31] ^ sum33[32];
            end
            OP_SLT: alu_f = {31'd0, (a_q < b_q)};
            OP_SLL: begin
                // Any shift amount of 32 or more clears the result.
                if (|a_q[31:5]) begin
                    alu_f = 32'd0;
                end else begin
                    alu_f = b_q << a_q[4:0];
                end
            end
            default: alu_f = 32'd0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------------

    // Control FSM and execution countdown.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            exec_cnt <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state    <= ST_EXEC;
                        exec_cnt <= EXEC_LOAD;
                    end
                end
                ST_EXEC: begin
                    if (exec_cnt == 4'd0) begin
                        state <= ST_RESP;
                    end else begin
                        exec_cnt <= exec_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_valid && rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    exec_cnt <= 4'd0;
                end
            endcase
        end
    end

    // Capture the granted requester's command on the handshake.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            op_q       <= 3'd0;
            a_q        <= 32'd0;
            b_q        <= 32'd0;
            last_grant <= 1'b1;
        end else if (accept) begin
            op_q       <= grant ? req1_op : req0_op;
            a_q        <= grant ? req1_a  : req0_a;
            b_q        <= grant ? req1_b  : req0_b;
            last_grant <= grant;
        end
    end

    // Response channel: load at the end of EXEC, hold until consumed.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_f     <= 32'd0;
            rsp_zf    <= 1'b0;
            rsp_of    <= 1'b0;
        end else if (exec_done) begin
            rsp_valid <= 1'b1;
            rsp_id    <= last_grant;
            rsp_f     <= alu_f;
            rsp_zf    <= (alu_f == 32'd0);
            rsp_of    <= alu_of;
        end else if (rsp_fire) begin
            rsp_valid <= 1'b0;
        end
    end

    // Completed-response counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            op_count <= '0;
        end else if (rsp_fire) begin
            op_count <= op_count + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Self-checking bench for alu_arbiter. Directed cases plus
//               randomized traffic compared against a behavioural model.
//               Honours ALU_ARB_ROUND_ROBIN_EN for contention expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    localparam int EXEC  = 4;
    localparam int CNT_W = 16;

    logic             clock = 1'b0;
    logic             rst   = 1'b0;
    logic             req0_valid = 1'b0, req1_valid = 1'b0;
    logic             req0_ready, req1_ready;
    logic [2:0]       req0_op = 3'd0, req1_op = 3'd0;
    logic [31:0]      req0_a = 32'd0, req0_b = 32'd0, req1_a = 32'd0, req1_b = 32'd0;
    logic             rsp_valid, rsp_id, rsp_zf, rsp_of, busy;
    logic             rsp_ready = 1'b1;
    logic [31:0]      rsp_f;
    logic [CNT_W-1:0] op_count;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int model_count = 0;
    bit model_last  = 1'b1;

    always #5 clock = ~clock;

    alu_arbiter #(.EXEC_CYCLES(EXEC), .CNT_W(CNT_W)) dut (
        .clock      (clock),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_f      (rsp_f),
        .rsp_zf     (rsp_zf),
        .rsp_of     (rsp_of),
        .busy       (busy),
        .op_count   (op_count)
    );

    // Behavioural ALU: signed overflow from the true mathematical result.
    function automatic void model_alu(input logic [2:0] op, input logic [31:0] a,
                                      input logic [31:0] b, output logic [31:0] f,
                                      output logic zf, output logic of);
        longint sa, sb, sr, lim;
        lim = 64'sd2147483648;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        of  = 1'b0;
        sr  = 0;
        case (op)
            3'd0: f = a & b;
            3'd1: f = a | b;
            3'd2: f = a ^ b;
            3'd3: f = ~(a | b);
            3'd4: begin sr = sa + sb; f = a + b; of = (sr >= lim) || (sr < -lim); end
            3'd5: begin sr = sa - sb; f = a - b; of = (sr >= lim) || (sr < -lim); end
            3'd6: f = (a < b) ? 32'd1 : 32'd0;
            default: f = (a >= 32'd32) ? 32'd0 : (b << a);
        endcase
        zf = (f == 32'd0);
    endfunction

    // Expected winner given which requesters are valid.
    function automatic int model_grant(input bit v0, input bit v1);
        if (v0 && v1) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
            return model_last ? 0 : 1;
`else
            return 0;
`endif
        end
        return v1 ? 1 : 0;
    endfunction

    // Drives one command, waits for its response and returns observations.
    // gnt: 0/1 granted requester, 2 both ready, -1 none within bound.
    // lat: cycles from accept to first rsp_valid, -1 on timeout.
    task automatic do_txn(input bit v0, input bit v1,
                          input logic [2:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                          input logic [2:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                          input int hold, output int gnt, output logic [31:0] f,
                          output logic zf, output logic of, output logic rid, output int lat);
        int n;
        gnt = -1; lat = -1; f = 'x; zf = 1'bx; of = 1'bx; rid = 1'bx;
        @(negedge clock);
        req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
        rsp_ready  = (hold == 0);
        #1;
        n = 0;
        while (!req0_ready && !req1_ready && n < 20) begin
            @(negedge clock); #1; n++;
        end
        if (req0_ready && req1_ready) gnt = 2;
        else if (req0_ready)          gnt = 0;
        else if (req1_ready)          gnt = 1;
        if (gnt < 0) begin
            req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
            return;
        end
        @(posedge clock);
        @(negedge clock);
        req0_valid = 1'b0; req1_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(negedge clock); lat++;
        end
        if (!rsp_valid) begin
            lat = -1; rsp_ready = 1'b1;
            return;
        end
        repeat (hold) @(negedge clock);
        f = rsp_f; zf = rsp_zf; of = rsp_of; rid = rsp_id;
        rsp_ready = 1'b1;
        @(negedge clock);
    endtask

    task automatic apply_reset();
        @(negedge clock);
        rst = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        repeat (2) @(negedge clock);
        rst = 1'b1;
        model_last  = 1'b1;
        model_count = 0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if ({rsp_valid, rsp_id, rsp_zf, rsp_of, busy, req0_ready, req1_ready} !== 7'd0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b want 0000000",
                     {rsp_valid, rsp_id, rsp_zf, rsp_of, busy, req0_ready, req1_ready});
        end
        checks++;
        if (rsp_f !== 32'd0) begin
            failures++; $display("FAIL reset_rsp_f: got %h want 0", rsp_f);
        end
        checks++;
        if (op_count !== '0) begin
            failures++; $display("FAIL reset_op_count: got %0d want 0", op_count);
        end
        rst = 1'b1;
        model_last = 1'b1; model_count = 0;
    endtask

    task automatic test_add_basic();
        int g, lat; logic [31:0] f; logic zf, of, rid;
        do_txn(1, 0, 3'd4, 32'h3, 32'h607, 3'd0, 32'd0, 32'd0, 0, g, f, zf, of, rid, lat);
        model_count++; model_last = 1'b0;
        checks++;
        if (g !== 0) begin failures++; $display("FAIL add_grant: got %0d want 0", g); end
        checks++;
        if ({f, zf, of, rid} !== {32'h0000060A, 3'b000}) begin
            failures++; $display("FAIL add_result: got f=%h zf=%b of=%b id=%b want f=0000060a zf=0 of=0 id=0", f, zf, of, rid);
        end
        checks++;
        if (lat !== EXEC + 1) begin failures++; $display("FAIL add_latency: got %0d want %0d", lat, EXEC + 1); end
        checks++;
        if (op_count !== CNT_W'(model_count)) begin
            failures++; $display("FAIL add_op_count: got %0d want %0d", op_count, model_count);
        end
    endtask

    task automatic test_overflow();
        int g, lat; logic [31:0] f; logic zf, of, rid;
        do_txn(0, 1, 3'd0, 32'd0, 32'd0, 3'd4, 32'h7FFFFFFF, 32'h7FFFFFFF, 0, g, f, zf, of, rid, lat);
        model_count++; model_last = 1'b1;
        checks++;
        if ({g == 1, f, zf, of, rid} !== {1'b1, 32'hFFFFFFFE, 3'b011}) begin
            failures++; $display("FAIL add_ovf: got g=%0d f=%h zf=%b of=%b id=%b want g=1 f=fffffffe zf=0 of=1 id=1", g, f, zf, of, rid);
        end
        do_txn(0, 1, 3'd0, 32'd0, 32'd0, 3'd5, 32'h80000000, 32'h80000000, 0, g, f, zf, of, rid, lat);
        model_count++; model_last = 1'b1;
        checks++;
        if ({g == 1, f, zf, of, rid} !== {1'b1, 32'h0, 3'b101}) begin
            failures++; $display("FAIL sub_zero: got g=%0d f=%h zf=%b of=%b id=%b want g=1 f=0 zf=1 of=0 id=1", g, f, zf, of, rid);
        end
        checks++;
        if (op_count !== CNT_W'(model_count)) begin
            failures++; $display("FAIL ovf_op_count: got %0d want %0d", op_count, model_count);
        end
    endtask

    task automatic test_sll();
        int g, lat; logic [31:0] f; logic zf, of, rid;
        do_txn(1, 0, 3'd7, 32'd4, 32'h1, 3'd0, 32'd0, 32'd0, 0, g, f, zf, of, rid, lat);
        model_count++; model_last = 1'b0;
        checks++;
        if ({f, zf, of} !== {32'h00000010, 2'b00}) begin
            failures++; $display("FAIL sll_4: got f=%h zf=%b of=%b want f=00000010 zf=0 of=0", f, zf, of);
        end
        do_txn(1, 0, 3'd7, 32'd32, 32'h1, 3'd0, 32'd0, 32'd0, 0, g, f, zf, of, rid, lat);
        model_count++; model_last = 1'b0;
        checks++;
        if ({f, zf} !== {32'h0, 1'b1}) begin
            failures++; $display("FAIL sll_32: got f=%h zf=%b want f=0 zf=1", f, zf);
        end
    endtask

    task automatic test_backpressure();
        int n;
        @(negedge clock);
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_op = 3'd6; req0_a = 32'hFFFFFFFF; req0_b = 32'h80000000;
        #1; n = 0;
        while (!req0_ready && n < 20) begin @(negedge clock); #1; n++; end
        @(posedge clock);
        @(negedge clock);
        req0_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 40) begin @(negedge clock); n++; end
        checks++;
        if (rsp_valid !== 1'b1) begin failures++; $display("FAIL bp_rsp_valid: got %b want 1", rsp_valid); end
        // Both requesters now wait; nothing may be accepted while in RESP.
        req0_valid = 1'b1; req1_valid = 1'b1; req1_op = 3'd4; req1_a = 32'h5; req1_b = 32'h6;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if ({rsp_valid, busy, req0_ready, req1_ready, rsp_id, rsp_f} !== {5'b11000, 32'h0}) begin
                failures++;
                $display("FAIL bp_hold[%0d]: got v=%b busy=%b r0=%b r1=%b id=%b f=%h want v=1 busy=1 r0=0 r1=0 id=0 f=0",
                         i, rsp_valid, busy, req0_ready, req1_ready, rsp_id, rsp_f);
            end
            @(negedge clock);
        end
        rsp_ready = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clock);
        model_count++; model_last = 1'b0;
        checks++;
        if ({rsp_valid, busy} !== 2'b00 || op_count !== CNT_W'(model_count)) begin
            failures++; $display("FAIL bp_release: got v=%b busy=%b cnt=%0d want v=0 busy=0 cnt=%0d",
                                 rsp_valid, busy, op_count, model_count);
        end
    endtask

    task automatic test_random();
        int g, eg, lat, hold, sel;
        bit v0, v1;
        logic [2:0] op0, op1;
        logic [31:0] a0, b0, a1, b1, f, ef;
        logic zf, of, rid, ezf, eof;
        for (int it = 0; it < 30; it++) begin
            sel = $urandom_range(0, 2);
            v0 = (sel != 1); v1 = (sel != 0);
            op0 = 3'($urandom_range(0, 7)); op1 = 3'($urandom_range(0, 7));
            a0 = $urandom(); b0 = $urandom(); a1 = $urandom(); b1 = $urandom();
            if ($urandom_range(0, 1) == 1) a0 = $urandom_range(0, 40);
            if ($urandom_range(0, 1) == 1) a1 = $urandom_range(0, 40);
            hold = $urandom_range(0, 3);
            eg = model_grant(v0, v1);
            if (eg == 0) model_alu(op0, a0, b0, ef, ezf, eof);
            else         model_alu(op1, a1, b1, ef, ezf, eof);
            do_txn(v0, v1, op0, a0, b0, op1, a1, b1, hold, g, f, zf, of, rid, lat);
            model_last = (eg == 1); model_count++;
            checks++;
            if (g !== eg) begin failures++; $display("FAIL rnd_grant[%0d]: got %0d want %0d", it, g, eg); end
            checks++;
            if ({f, zf, of} !== {ef, ezf, eof}) begin
                failures++; $display("FAIL rnd_result[%0d]: got f=%h zf=%b of=%b want f=%h zf=%b of=%b",
                                     it, f, zf, of, ef, ezf, eof);
            end
            checks++;
            if (rid !== 1'(eg)) begin failures++; $display("FAIL rnd_id[%0d]: got %b want %0d", it, rid, eg); end
            checks++;
            if (lat !== EXEC + 1) begin failures++; $display("FAIL rnd_latency[%0d]: got %0d want %0d", it, lat, EXEC + 1); end
            checks++;
            if (op_count !== CNT_W'(model_count)) begin
                failures++; $display("FAIL rnd_op_count[%0d]: got %0d want %0d", it, op_count, model_count);
            end
        end
    endtask

    task automatic test_contention();
        int grants[$];
        int ids[$];
        logic [31:0] fs[$];
        logic [31:0] ef;
        logic ezf, eof;
        int n, eg;
        apply_reset();
        @(negedge clock);
        req0_op = 3'd4; req0_a = $urandom(); req0_b = $urandom();
        req1_op = 3'd2; req1_a = $urandom(); req1_b = $urandom();
        rsp_ready = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
        n = 0;
        while (ids.size() < 4 && n < 200) begin
            #1;
            if (req0_ready && req1_ready) begin
                checks++; failures++; $display("FAIL cont_both_ready: got 2 readies want 1");
            end
            if (req0_ready)      grants.push_back(0);
            else if (req1_ready) grants.push_back(1);
            if (rsp_valid) begin
                ids.push_back(int'(rsp_id));
                fs.push_back(rsp_f);
            end
            if (ids.size() == 4) begin req0_valid = 1'b0; req1_valid = 1'b0; end
            @(negedge clock); n++;
        end
        checks++;
        if (ids.size() != 4 || grants.size() != 4) begin
            failures++; $display("FAIL cont_count: got grants=%0d rsps=%0d want 4 4", grants.size(), ids.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                eg = model_grant(1, 1);
                if (eg == 0) model_alu(req0_op, req0_a, req0_b, ef, ezf, eof);
                else         model_alu(req1_op, req1_a, req1_b, ef, ezf, eof);
                model_last = (eg == 1); model_count++;
                checks++;
                if (grants[i] != eg || ids[i] != eg || fs[i] !== ef) begin
                    failures++; $display("FAIL cont_seq[%0d]: got grant=%0d id=%0d f=%h want grant=%0d id=%0d f=%h",
                                         i, grants[i], ids[i], fs[i], eg, eg, ef);
                end
            end
        end
        checks++;
        if (op_count !== CNT_W'(model_count)) begin
            failures++; $display("FAIL cont_op_count: got %0d want %0d", op_count, model_count);
        end
    endtask

    task automatic test_reset_mid_exec();
        int n, g, lat, stale;
        logic [31:0] f, ef, a, b;
        logic zf, of, rid, ezf, eof;
        @(negedge clock);
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_op = 3'd1; req0_a = 32'hA5A5_0000; req0_b = 32'h0000_5A5A;
        #1; n = 0;
        while (!req0_ready && n < 20) begin @(negedge clock); #1; n++; end
        @(posedge clock);
        @(negedge clock);
        req0_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({rsp_valid, rsp_id, rsp_zf, rsp_of, busy} !== 5'd0 || rsp_f !== 32'd0 || op_count !== '0) begin
            failures++; $display("FAIL async_reset: got v=%b id=%b zf=%b of=%b busy=%b f=%h cnt=%0d want all 0",
                                 rsp_valid, rsp_id, rsp_zf, rsp_of, busy, rsp_f, op_count);
        end
        @(negedge clock);
        rst = 1'b1;
        model_last = 1'b1; model_count = 0;
        stale = 0;
        repeat (EXEC + 4) begin
            @(negedge clock);
            if (rsp_valid || busy) stale++;
        end
        checks++;
        if (stale != 0) begin failures++; $display("FAIL no_stale_rsp: got %0d active cycles want 0", stale); end
        a = $urandom(); b = $urandom();
        model_alu(3'd5, a, b, ef, ezf, eof);
        do_txn(1, 1, 3'd5, a, b, 3'd0, 32'hFFFF, 32'hFF, 0, g, f, zf, of, rid, lat);
        model_count++; model_last = 1'b0;
        checks++;
        if (g !== 0 || rid !== 1'b0 || {f, zf, of} !== {ef, ezf, eof}) begin
            failures++; $display("FAIL post_reset_grant: got g=%0d id=%b f=%h want g=0 id=0 f=%h", g, rid, f, ef);
        end
        checks++;
        if (op_count !== CNT_W'(model_count)) begin
            failures++; $display("FAIL post_reset_op_count: got %0d want %0d", op_count, model_count);
        end
    endtask

    initial begin
        test_reset();
        test_add_basic();
        test_overflow();
        test_sll();
        test_backpressure();
        test_random();
        test_contention();
        test_reset_mid_exec();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one instance of the team's 32-bit ALU between two requesters. Each requester issues (op, A, B) over a valid/ready handshake.
- The block arbitrates, registers operands, runs the ALU for a fixed number of cycles, and returns F/ZF/OF with a requester ID on a single valid/ready response channel.
- Sits between the test/control logic and the ALU, replacing direct switch-driven operand muxing.

Parameters:
- EXEC_CYCLES, 1, cycles spent in EXEC before the result is captured; legal range 1..15.
- CNT_W, 16, width of completed-operation counter.

Ports:
- clock  in  1  system clock, rising edge
- rst  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has a command
- req0_ready  out  1  requester 0 command accepted this cycle
- req0_op  in  3  ALU op: 0 and, 1 or, 2 xor, 3 nor, 4 add, 5 sub, 6 slt (unsigned), 7 sll (B<<A)
- req0_a  in  32  operand A
- req0_b  in  32  operand B
- req1_valid / req1_ready / req1_op / req1_a / req1_b  same as requester 0
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  1  requester that issued the result
- rsp_f  out  32  ALU result F
- rsp_zf  out  1  F==0
- rsp_of  out  1  signed overflow (add/sub only, else 0)
- busy  out  1  state != IDLE
- op_count  out  CNT_W  completed responses, wraps modulo 2^CNT_W

Behaviour:
- Clocking and reset: single clock, rst asynchronous active-low.
- Reset values: state=IDLE, all outputs 0, last_grant=1 (so req0 wins first contention), op/a/b/id registers 0, exec counter 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - grant = single valid requester; if both valid, grant = ~last_grant.
  - reqN_ready = (state==IDLE) && (grant==N) && reqN_valid. The ready signal is combinational and at most one is high.
  - On handshake: capture op/a/b/id, set last_grant=id, load exec counter with EXEC_CYCLES-1, go to EXEC.
  - No valid request: stay in IDLE.
- EXEC:
  - ALU is driven only from the captured registers. Requester inputs are ignored.
  - Counter decrements each cycle. When it reaches 0, register F/ZF/OF into rsp_f/rsp_zf/rsp_of, set rsp_id, assert rsp_valid, go to RESP.
- RESP:
  - rsp_* are held stable while rsp_valid && !rsp_ready.
  - On rsp_valid && rsp_ready: deassert rsp_valid, op_count+1 (wraps), go to IDLE.
  - No new request is accepted in the same cycle.
- Latency: request accepted in cycle N gives rsp_valid high from cycle N+1+EXEC_CYCLES. Minimum issue interval is EXEC_CYCLES+2 cycles.
- Requester rules: requesters hold valid and payload stable until ready. Deasserting valid before ready is legal and simply withdraws the request. Payload changes while not granted are ignored.
- ALU arithmetic:
  - add/sub: 33-bit {C32,F}; OF = A[31]^B[31]^F[31]^C32.
  - slt: unsigned compare, F=1 or 0.
  - sll: shift amount is the full 32-bit A; any amount >=32 gives F=0.
  - ZF = (F==0) for every op.
- rsp_ready is ignored outside RESP. It may be held high permanently, giving one-cycle RESP.
- Reset mid-EXEC or mid-RESP: the in-flight operation is discarded, no response is produced, op_count is cleared.

Optional Feature:
- Macro: ALU_ARB_ROUND_ROBIN_EN.
- Defined: round-robin contention as above (alternating grants under continuous dual requests).
- Undefined: fixed priority, requester 0 always wins contention. last_grant is still updated but unused, and requester 1 may starve.

Test Plan:
- req0 add A=0x00000003 B=0x00000607, rsp_ready=1 -> rsp_f=0x0000060A, zf=0, of=0, id=0, rsp_valid 2 cycles after accept (EXEC_CYCLES=1), op_count=1.
- req1 add A=B=0x7FFFFFFF -> rsp_f=0xFFFFFFFE, of=1, id=1. Then req1 sub A=B=0x80000000 -> rsp_f=0, zf=1, of=0.
- Both valid from reset, continuous (round-robin defined) -> grants 0,1,0,1 and rsp_id alternates. With the macro undefined -> all four responses have id=0.
- rsp_ready low for 5 cycles in RESP with slt A=0xFFFFFFFF B=0x80000000 -> rsp_f=0 held stable, busy=1, no ready to either requester. rsp_ready high -> one handshake, IDLE next cycle.
- sll B=0x00000001 A=4 -> rsp_f=0x00000010. sll A=32 -> rsp_f=0, zf=1.
- Assert rst low during EXEC (EXEC_CYCLES=4) -> all outputs 0 asynchronously. After release: no stale response, next grant goes to req0.
